// File: rtl/fft_cfg_pkg.sv
// Shared types and field-layout helpers for the FFT config master.
// Used by the RTL and by the testbench to locate fields in tdata.
package fft_cfg_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } cfg_state_t;

   function automatic int fft_cfg_cp_bits(input int cp_en, input int cp_w);
      return (cp_en != 0) ? 8 * ((cp_w + 7) / 8) : 0;
   endfunction

   function automatic int fft_cfg_cp_off(input int nfft_en);
      return (nfft_en != 0) ? 8 : 0;
   endfunction

   function automatic int fft_cfg_fwd_off(input int nfft_en,
                                          input int cp_en,
                                          input int cp_w);
      return fft_cfg_cp_off(nfft_en) + fft_cfg_cp_bits(cp_en, cp_w);
   endfunction

   function automatic int fft_cfg_scale_off(input int num_ch,
                                            input int nfft_en,
                                            input int cp_en,
                                            input int cp_w);
      return fft_cfg_fwd_off(nfft_en, cp_en, cp_w) + num_ch;
   endfunction

   function automatic int fft_cfg_tdata_w(input int num_ch,
                                          input int scale_w,
                                          input int nfft_en,
                                          input int cp_en,
                                          input int cp_w);
      int bits;
      bits = fft_cfg_scale_off(num_ch, nfft_en, cp_en, cp_w)
           + num_ch * scale_w;
      return 8 * ((bits + 7) / 8);
   endfunction

endpackage

// File: rtl/fft_cfg_pack.sv
// Combinational packer: config fields -> byte-aligned tdata word.
// Disabled fields are forced to zero so their inputs are don't-care.
module fft_cfg_pack
   import fft_cfg_pkg::*;
#(
   parameter int NUM_CH  = 1,
   parameter int SCALE_W = 8,
   parameter int NFFT_EN = 0,
   parameter int NFFT_W  = 5,
   parameter int CP_EN   = 0,
   parameter int CP_W    = 12,
   localparam int TDATA_W =
      fft_cfg_tdata_w(NUM_CH, SCALE_W, NFFT_EN, CP_EN, CP_W)
) (
   input  logic [NUM_CH*SCALE_W-1:0] i_scale_sch,
   input  logic [NUM_CH-1:0]         i_fwd_inv,
   input  logic [NFFT_W-1:0]         i_nfft,
   input  logic [CP_W-1:0]           i_cp_len,
   output logic [TDATA_W-1:0]        o_tdata
);

   localparam int CP_OFF    = fft_cfg_cp_off(NFFT_EN);
   localparam int FWD_OFF   = fft_cfg_fwd_off(NFFT_EN, CP_EN, CP_W);
   localparam int SCALE_OFF =
      fft_cfg_scale_off(NUM_CH, NFFT_EN, CP_EN, CP_W);
   localparam logic NFFT_ON = (NFFT_EN != 0);
   localparam logic CP_ON   = (CP_EN != 0);

   logic [TDATA_W-1:0] w_nfft_f;
   logic [TDATA_W-1:0] w_cp_f;
   logic [TDATA_W-1:0] w_fwd_f;
   logic [TDATA_W-1:0] w_scale_f;

   assign w_nfft_f  = NFFT_ON ? TDATA_W'(i_nfft) : '0;
   assign w_cp_f    = CP_ON ? (TDATA_W'(i_cp_len) << CP_OFF) : '0;
   assign w_fwd_f   = TDATA_W'(i_fwd_inv) << FWD_OFF;
   assign w_scale_f = TDATA_W'(i_scale_sch) << SCALE_OFF;

   assign o_tdata = w_nfft_f | w_cp_f | w_fwd_f | w_scale_f;

endmodule

// File: rtl/fft_config_mc.sv
// AXI-Stream config master: one single-beat transfer per commit,
// with a one-deep coalescing queue behind the outstanding beat.
module fft_config_mc
   import fft_cfg_pkg::*;
#(
   parameter int NUM_CH  = 1,
   parameter int SCALE_W = 8,
   parameter int NFFT_EN = 0,
   parameter int NFFT_W  = 5,
   parameter int CP_EN   = 0,
   parameter int CP_W    = 12,
   localparam int TDATA_W =
      fft_cfg_tdata_w(NUM_CH, SCALE_W, NFFT_EN, CP_EN, CP_W)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_CH*SCALE_W-1:0] scale_sch,
   input  logic [NUM_CH-1:0]         fwd_inv,
   input  logic [NFFT_W-1:0]         nfft,
   input  logic [CP_W-1:0]           cp_len,
   input  logic                      commit,
   input  logic                      clr_status,
   input  logic                      tready,
   output logic                      tvalid,
   output logic                      tlast,
   output logic [TDATA_W-1:0]        tdata,
   output logic                      busy,
   output logic                      cfg_overwrite,
   output logic [15:0]               cfg_sent_cnt
);

   cfg_state_t         r_state;
   cfg_state_t         w_state_nxt;
   logic [TDATA_W-1:0] r_tdata;
   logic [TDATA_W-1:0] r_shadow;
   logic               r_pending;
   logic               r_overwrite;
   logic [15:0]        r_cnt;

   logic [TDATA_W-1:0] w_pack;
   logic               w_hs;
   logic               w_load_in;
   logic               w_load_sh;
   logic               w_pend_nxt;
   logic               w_ovw_set;

   fft_cfg_pack #(
      .NUM_CH  (NUM_CH),
      .SCALE_W (SCALE_W),
      .NFFT_EN (NFFT_EN),
      .NFFT_W  (NFFT_W),
      .CP_EN   (CP_EN),
      .CP_W    (CP_W)
   ) u_pack (
      .i_scale_sch (scale_sch),
      .i_fwd_inv   (fwd_inv),
      .i_nfft      (nfft),
      .i_cp_len    (cp_len),
      .o_tdata     (w_pack)
   );

   // tvalid comes straight from state, so tready never reaches it comb.
   assign w_hs = (r_state == ST_VALID) && tready;

   always_comb begin
      w_state_nxt = r_state;
      w_load_in   = 1'b0;
      w_load_sh   = 1'b0;
      w_pend_nxt  = r_pending;
      w_ovw_set   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (commit) begin
               w_state_nxt = ST_VALID;
               w_load_in   = 1'b1;
            end
         end
         ST_VALID: begin
            if (w_hs) begin
               if (commit) begin
                  w_load_in  = 1'b1;
                  w_pend_nxt = 1'b0;
                  w_ovw_set  = r_pending;
               end else if (r_pending) begin
                  w_load_sh  = 1'b1;
                  w_pend_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (commit) begin
               w_pend_nxt = 1'b1;
               w_ovw_set  = r_pending;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tdata     <= '0;
         r_shadow    <= '0;
         r_pending   <= 1'b0;
         r_overwrite <= 1'b0;
         r_cnt       <= '0;
      end else begin
         if (w_load_in) begin
            r_tdata <= w_pack;
         end else if (w_load_sh) begin
            r_tdata <= r_shadow;
         end
         if (commit) begin
            r_shadow <= w_pack;
         end
         r_pending <= w_pend_nxt;
         // A fresh overwrite beats a simultaneous clear.
         if (w_ovw_set) begin
            r_overwrite <= 1'b1;
         end else if (clr_status) begin
            r_overwrite <= 1'b0;
         end
         if (w_hs) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign tvalid        = (r_state == ST_VALID);
   assign tlast         = (r_state == ST_VALID);
   assign tdata         = r_tdata;
   assign busy          = (r_state == ST_VALID) || r_pending;
   assign cfg_overwrite = r_overwrite;
   assign cfg_sent_cnt  = r_cnt;

endmodule

// File: doc/fft_config_mc.md
# fft_config_mc

Parametrised AXI-Stream configuration master for the FFT core's config channel. It generalises the single-channel scale/direction loader to N channels, with optional runtime point-size (NFFT) and cyclic-prefix fields. Commits arriving while a transfer is outstanding are queued, not lost. It sits between the register map and the FFT core's `s_axis_config` port and emits one single-beat transfer per accepted commit.

## Interface

Parameters:
- `NUM_CH`, 1: number of channels; one direction bit and one scale schedule per channel.
- `SCALE_W`, 8: scale-schedule width per channel.
- `NFFT_EN`, 0: 1 adds the NFFT field.
- `NFFT_W`, 5: NFFT width, at most 8.
- `CP_EN`, 0: 1 adds the CP_LEN field.
- `CP_W`, 12: CP_LEN width.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `scale_sch` in NUM_CH*SCALE_W: channel c occupies bits [c*SCALE_W +: SCALE_W].
- `fwd_inv` in NUM_CH: 1 = forward transform.
- `nfft` in NFFT_W: log2 of the point size. Ignored when NFFT_EN=0.
- `cp_len` in CP_W: cyclic-prefix length. Ignored when CP_EN=0.
- `commit` in 1: single-cycle request to send the current inputs.
- `clr_status` in 1: clears `cfg_overwrite`.
- `tready` in 1: AXI-S ready.
- `tvalid` out 1: AXI-S valid.
- `tlast` out 1: AXI-S last.
- `tdata` out TDATA_W: packed configuration word.
- `busy` out 1: high when in VALID or when a commit is pending.
- `cfg_overwrite` out 1: sticky flag; a pending commit was replaced by a newer one.
- `cfg_sent_cnt` out 16: count of completed handshakes; wraps from 0xFFFF to 0.

## Operation

tdata packing, from the LSB upward:
- NFFT: zero-extended to 8 bits, present only if NFFT_EN.
- CP_LEN: zero-extended to 8*ceil(CP_W/8) bits, present only if CP_EN.
- `fwd_inv[NUM_CH-1:0]`.
- `scale_sch`.
- Zero padding to the next byte boundary. TDATA_W is the resulting byte-multiple width, a derived localparam.

Registers:
- Shadow word: captures the packed inputs on every `commit`.
- `pending`: one bit.

States:
- IDLE: `tvalid`=0. On `commit`, capture the inputs into `tdata` and move to VALID.
- VALID: `tvalid`=1 and `tlast`=1. `tdata` is held stable until the handshake.
  - `commit` without a handshake: the shadow captures the inputs and `pending` is set.
  - If `pending` was already set, the shadow is overwritten (latest wins) and `cfg_overwrite` is set.
  - On handshake (`tvalid`&&`tready`), `cfg_sent_cnt` increments, then:
    - If `commit` occurs in the same cycle, load the inputs directly into `tdata` and stay in VALID.
    - Else if `pending`, load the shadow into `tdata`, clear `pending` and stay in VALID.
    - Otherwise go to IDLE.
  - Back-to-back transfers keep `tvalid` high continuously.
- If `clr_status` and a new overwrite event occur in the same cycle, set wins.

## Timing

- Reset state: IDLE. `tvalid`, `tlast`, `tdata`, `pending`, `busy`, `cfg_overwrite` and `cfg_sent_cnt` are all 0.
- Commit latency: `commit` at cycle N gives `tvalid`=1 at N+1, with `tdata` equal to the inputs sampled at N.
- Input changes after the commit edge never affect an outstanding `tdata`.
- `tvalid` never deasserts without a handshake, except on reset.
- The block accepts `tready` before `tvalid` and has no combinational path from `tready` to `tvalid`.
- Reset mid-transfer: all outputs return to their reset values asynchronously; the pending commit is discarded.
- At most one transfer can be queued behind the outstanding one; further commits coalesce into it.

## Structure

- Shared package `fft_cfg_pkg` holds:
  - the state encoding (IDLE=0, VALID=1);
  - the `fft_cfg_tdata_w()` width function;
  - the field-offset functions used by both this block and the bench.
- Sub-module `fft_cfg_pack` is a combinational packer from the input fields to a TDATA_W word. The block instantiates it once and the bench reuses it as its reference model.

## Test plan

1. Defaults (NUM_CH=1, SCALE_W=8, NFFT_EN=0, CP_EN=0). Drive `fwd_inv`=1, `scale_sch`=0xAA and pulse `commit`, with `tready`=1. Required: `tvalid`=1 for exactly one cycle at N+1, `tdata`=16'h0155, `tlast`=1, `cfg_sent_cnt`=1.
2. NFFT_EN=1 with `nfft`=10, `fwd_inv`=1, `scale_sch`=0xAA. Required: TDATA_W=24 and `tdata`=24'h01550A.
3. Hold `tready`=0 and commit A=0x0155. Change the inputs for 5 cycles, then raise `tready`. Required: `tdata` stays 0x0155 throughout, `tvalid` stays high, and exactly one handshake occurs.
4. With A outstanding, commit B then C; release `tready` for 2 cycles. Required:
   - handshakes deliver A then C back-to-back, with no `tvalid` gap;
   - `cfg_overwrite`=1 until `clr_status`;
   - `cfg_sent_cnt`=2.
5. Commit coincident with the handshake of A. Required: the next beat is the new word at the following cycle and `pending` stays 0.
6. Deassert `resetn` while `tvalid`=1 with a commit pending. Required: all outputs are 0 immediately, and no transfer occurs after release until a fresh `commit`.
